regfile_dump_reader: RTL and testbench

//  Read-side initiator for the 64x16 register file. On Start it walks an address range on

---
 rtl/regdump_pkg.sv | 15 +
 rtl/regfile_dump_reader.sv | 164 ++++++++++++++++
 tb/tb_regfile_dump_reader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regdump_pkg.sv
// Shared types and default sizes for the register-file dump reader.
package regdump_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4
  } dumpState_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks [FirstAddr..LastAddr] (wrapping) on read
// port B and streams (address, data) words over a valid/ready interface.
// Optional feature macro: REGDUMP_CHECKSUM_EN appends one XOR checksum word
// (OutAddr=0, OutLast=1) after the last register word.
//
// state | meaning
// IDLE  | waiting for Start
// FETCH | RfAddress is stable, capture RfReadData into the output word
// HOLD  | word presented, waiting for OutReady
// CSUM  | checksum word presented (macro build only)
// DONE  | one-cycle Done pulse
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] FirstAddr,
  input  logic [ADDR_W-1:0] LastAddr,
  output logic [ADDR_W-1:0] RfAddress,
  input  logic [DATA_W-1:0] RfReadData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [ADDR_W-1:0] OutAddr,
  output logic              OutLast,
  output logic              Busy,
  output logic              Done
);

  dumpState_t        state;
  dumpState_t        nextState;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] last;
  logic [ADDR_W-1:0] nextCur;
  logic              handshake;
  logic              isLast;
  logic              abortNow;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  assign handshake = OutValid && OutReady;
  assign isLast    = (cur == last);
  assign nextCur   = cur + ADDR_W'(1);
  assign abortNow  = Abort && (state != IDLE);
  assign Busy      = (state != IDLE);
  assign Done      = (state == DONE);

  // State register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state decode; Abort overrides every transition out of a busy state.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (Start) nextState = FETCH;
      FETCH: nextState = HOLD;
      HOLD: begin
        if (handshake) begin
          if (isLast) begin
`ifdef REGDUMP_CHECKSUM_EN
            nextState = CSUM;
`else
            nextState = DONE;
`endif
          end else begin
            nextState = FETCH;
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM:  if (handshake) nextState = DONE;
`endif
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (abortNow) nextState = IDLE;
  end

  // Address counter, output word and checksum.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cur       <= '0;
      last      <= '0;
      RfAddress <= '0;
      OutValid  <= 1'b0;
      OutData   <= '0;
      OutAddr   <= '0;
      OutLast   <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else if (abortNow) begin
      // Cancelled dump leaves the interface quiet; the pending word is dropped.
      RfAddress <= '0;
      OutValid  <= 1'b0;
      OutData   <= '0;
      OutAddr   <= '0;
      OutLast   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            cur       <= FirstAddr;
            last      <= LastAddr;
            RfAddress <= FirstAddr;
`ifdef REGDUMP_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        end
        FETCH: begin
          OutData  <= RfReadData;
          OutAddr  <= cur;
          OutValid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          OutLast  <= 1'b0;
`else
          OutLast  <= isLast;
`endif
        end
        HOLD: begin
          if (handshake) begin
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum     <= csum ^ OutData;
`endif
            if (isLast) begin
`ifdef REGDUMP_CHECKSUM_EN
              // Present the checksum word straight away, including this last word.
              OutValid <= 1'b1;
              OutData  <= csum ^ OutData;
              OutAddr  <= '0;
              OutLast  <= 1'b1;
`endif
            end else begin
              cur       <= nextCur;
              RfAddress <= nextCur;
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        CSUM: begin
          if (handshake) begin
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader with a behavioural register file.
// Honours REGDUMP_CHECKSUM_EN to expect the trailing checksum word.
module tb_regfile_dump_reader;
  import regdump_pkg::*;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int NREG = 64;
`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          nReset;
  logic          Start;
  logic          Abort;
  logic [AW-1:0] FirstAddr;
  logic [AW-1:0] LastAddr;
  logic [AW-1:0] RfAddress;
  logic [DW-1:0] RfReadData;
  logic          OutValid;
  logic          OutReady;
  logic [DW-1:0] OutData;
  logic [AW-1:0] OutAddr;
  logic          OutLast;
  logic          Busy;
  logic          Done;

  logic [DW-1:0] regs [NREG];
  logic [22:0]   expQ [$];
  int            nCompared = 0;
  int            nMismatched = 0;
  int            doneSeen = 0;
  int            expDone = 0;
  int            readyMode = 1;
  int            stallCnt = 0;

  always #5 Clock = ~Clock;

  assign RfReadData = regs[RfAddress];

  regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock(Clock), .nReset(nReset), .Start(Start), .Abort(Abort),
    .FirstAddr(FirstAddr), .LastAddr(LastAddr), .RfAddress(RfAddress),
    .RfReadData(RfReadData), .OutValid(OutValid), .OutReady(OutReady),
    .OutData(OutData), .OutAddr(OutAddr), .OutLast(OutLast),
    .Busy(Busy), .Done(Done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int wordCount(input logic [AW-1:0] f, input logic [AW-1:0] l);
    return ((int'(l) - int'(f) + NREG) % NREG) + 1;
  endfunction

  // Reference model: range walk with wrap, optional XOR checksum word.
  task automatic pushExpected(input logic [AW-1:0] f, input logic [AW-1:0] l, input int keep);
    int n;
    logic [DW-1:0] cs;
    logic [AW-1:0] a;
    n  = wordCount(f, l);
    cs = '0;
    for (int i = 0; i < n; i++) begin
      a = AW'((int'(f) + i) % NREG);
      if (i < keep) expQ.push_back({(i == n - 1) && !CSUM_ON, a, regs[a]});
      cs = cs ^ regs[a];
    end
    if (CSUM_ON && keep >= n) expQ.push_back({1'b1, 6'd0, cs});
  endtask

  task automatic checkQuiet(input string name);
    check(name, 32'({OutValid, OutLast, Busy, Done, OutData, OutAddr, RfAddress}), 32'd0);
  endtask

  // OutReady driver: random, always-on, or a 5-cycle stall on the addr-2 word.
  initial begin
    OutReady = 1'b0;
    forever begin
      @(posedge Clock); #1;
      case (readyMode)
        0: OutReady = ($urandom_range(0, 2) != 0);
        2: begin
          if (OutValid && OutAddr == 6'd2 && stallCnt < 5) begin
            OutReady = 1'b0;
            stallCnt++;
          end else OutReady = 1'b1;
        end
        default: OutReady = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted word and checks stalls hold the word.
  initial begin
    logic [22:0] act;
    logic [22:0] prevWord;
    logic [22:0] exp;
    bit          prevStalled;
    prevStalled = 1'b0;
    prevWord = '0;
    forever begin
      @(negedge Clock);
      act = {OutLast, OutAddr, OutData};
      if (nReset && OutValid) begin
        if (prevStalled) check("stall_hold", 32'(act), 32'(prevWord));
        if (OutReady && !Abort) begin
          if (expQ.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL extra_word: got %h expected none", act);
          end else begin
            exp = expQ.pop_front();
            check("word", 32'(act), 32'(exp));
          end
          prevStalled = 1'b0;
        end else begin
          prevStalled = !Abort;
          prevWord = act;
        end
      end else prevStalled = 1'b0;
      if (nReset && Done) doneSeen++;
    end
  end

  task automatic runDump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int mode, input bit midStart);
    int  cycles;
    int  n;
    bit  gotDone;
    readyMode = mode;
    n = wordCount(f, l);
    pushExpected(f, l, NREG + 1);
    expDone++;
    @(posedge Clock); #1;
    FirstAddr = f; LastAddr = l; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    cycles = 0;
    gotDone = 1'b0;
    while (!gotDone && cycles < 4000) begin
      @(negedge Clock);
      cycles++;
      if (midStart && cycles == 5) begin
        FirstAddr = f + 6'd7; Start = 1'b1;
      end else Start = 1'b0;
      if (Done) gotDone = 1'b1;
    end
    Start = 1'b0;
    check("done_seen", 32'(gotDone), 32'd1);
    if (mode == 1) check("latency", 32'(cycles), 32'(2 * n + 1 + int'(CSUM_ON)));
    @(negedge Clock);
    check("done_pulse", 32'({Done, Busy}), 32'd0);
    check("queue_drained", 32'(expQ.size()), 32'd0);
    check("done_count", 32'(doneSeen), 32'(expDone));
  endtask

  task automatic randomizeRegs();
    for (int i = 0; i < NREG; i++) regs[i] = DW'($urandom);
  endtask

  initial begin
    int  k;
    bit  found;
    logic [AW-1:0] f;
    logic [AW-1:0] l;
    nReset = 1'b0; Start = 1'b0; Abort = 1'b0; FirstAddr = '0; LastAddr = '0;
    randomizeRegs();
    repeat (3) @(posedge Clock);
    #1 checkQuiet("reset_outputs");
    @(negedge Clock) nReset = 1'b1;

    // Directed: 1..6 with known end registers, then a stall on addr 2.
    regs[1] = 16'h3D3A;
    regs[6] = 16'h000A;
    runDump(6'd1, 6'd6, 1, 1'b0);
    stallCnt = 0;
    runDump(6'd1, 6'd6, 2, 1'b0);
    check("stall_applied", 32'(stallCnt), 32'd5);

    // Wrapping range and single-word range.
    runDump(6'd62, 6'd1, 1, 1'b0);
    runDump(6'd5, 6'd5, 1, 1'b0);

    // Abort while word 3 is presented: only words 1 and 2 transfer.
    readyMode = 1;
    pushExpected(6'd1, 6'd6, 2);
    @(posedge Clock); #1;
    FirstAddr = 6'd1; LastAddr = 6'd6; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    found = 1'b0;
    k = 0;
    while (!found && k < 100) begin
      @(posedge Clock); #1;
      k++;
      if (OutValid && OutAddr == 6'd3) found = 1'b1;
    end
    check("abort_word3_reached", 32'(found), 32'd1);
    Abort = 1'b1;
    @(posedge Clock); #1;
    Abort = 1'b0;
    checkQuiet("abort_outputs");
    repeat (5) @(negedge Clock);
    check("abort_no_done", 32'(doneSeen), 32'(expDone));
    check("abort_queue", 32'(expQ.size()), 32'd0);

    // Reset in the middle of a full-range dump.
    readyMode = 0;
    pushExpected(6'd0, 6'd63, NREG + 1);
    @(posedge Clock); #1;
    FirstAddr = 6'd0; LastAddr = 6'd63; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (30) @(posedge Clock);
    #1 nReset = 1'b0;
    #1 checkQuiet("reset_mid_dump");
    repeat (2) @(posedge Clock);
    #1 checkQuiet("reset_held");
    expQ.delete();
    @(negedge Clock) nReset = 1'b1;
    repeat (4) @(negedge Clock);
    check("reset_no_done", 32'(doneSeen), 32'(expDone));
    checkQuiet("after_reset_idle");

`ifdef REGDUMP_CHECKSUM_EN
    regs[1] = 16'h3D3A;
    regs[2] = 16'h000A;
    runDump(6'd1, 6'd2, 1, 1'b0);
`endif

    // Randomized ranges, contents, back-pressure and Start-while-busy pulses.
    for (int it = 0; it < 8; it++) begin
      randomizeRegs();
      f = AW'($urandom);
      l = AW'($urandom);
      runDump(f, l, int'($urandom_range(0, 1)),
              (wordCount(f, l) >= 4) && ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
    $fatal(1, "timeout");
  end

endmodule
